sc_div_operand_gen: RTL and testbench
=====================================

Name: sc_div_operand_gen

Overview:
Binary-to-stochastic encoder that produces the operand streams consumed by the in-stream correlation-based divider.
- Accepts a dividend/divisor word pair over a valid/ready handshake.
- Emits two maximally correlated unipolar bitstreams plus an independent random select bit (rand_num), for exactly one LFSR period per operand pair.
- Sits between the binary control/test side and the stochastic divider datapath.

Parameters:
WIDTH, 8, operand and LFSR width; legal 4..16.
SEED, 1, operand LFSR reseed value; nonzero, < 2^WIDTH.
SEED_R, 2^(WIDTH-1)+1, rand_num LFSR reseed value; nonzero, != SEED.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair offered
in_ready  out  1  generator can accept a pair this cycle
dividend_val  in  WIDTH  unsigned dividend word
divisor_val  in  WIDTH  unsigned divisor word
dividend  out  1  dividend bitstream
divisor  out  1  divisor bitstream
rand_num  out  1  independent random bit for the divider trace-register mux
stream_valid  out  1  stream bits valid this cycle
done  out  1  one-cycle pulse coincident with the last valid bit
err  out  1  one-cycle pulse: dividend_val > divisor_val at accept
hold  in  1  stall; present only with SC_SNG_HOLD_EN

Behaviour:
- Reset (async) values:
  - State IDLE.
  - Both LFSRs load their seeds; counter = 0; latched operands = 0.
  - stream_valid, dividend, divisor, rand_num, done, err = 0; in_ready = 1.
- Every output derives from registered state only; no combinational path from inputs to outputs.
- FSM states: IDLE, RUN.
- in_ready = (IDLE) or (RUN and counter == 2^WIDTH-2).
- Accept occurs when in_valid && in_ready. On accept:
  - Latch a_q = min(dividend_val, divisor_val) and b_q = divisor_val.
  - Reseed operand LFSR to SEED and rand LFSR to SEED_R.
  - Set counter to 0 and next state to RUN.
  - err = 1 on the next cycle iff dividend_val > divisor_val; dividend is then clamped to divisor.
- RUN:
  - stream_valid = 1.
  - dividend = (lfsr <= a_q) && (a_q != 0).
  - divisor = (lfsr <= b_q) && (b_q != 0).
  - rand_num = lfsr_r[WIDTH-1].
  - Each cycle, both LFSRs step and the counter increments.
  - RUN lasts exactly 2^WIDTH-1 cycles. Over one period the lfsr visits 1..2^WIDTH-1 once, so the ones count equals the operand value exactly.
  - Because a_q <= b_q and both comparators share lfsr, dividend=1 implies divisor=1 in every cycle.
- Latency: first valid bit is the cycle after accept.
- done = 1 in the RUN cycle with counter == 2^WIDTH-2.
  - With no accept that cycle: next state is IDLE.
  - With an accept that cycle: RUN restarts with counter 0, with no bubble in stream_valid.
- IDLE: stream_valid, dividend, divisor, rand_num = 0; LFSRs frozen.
- LFSRs: Fibonacci, maximal-length; taps come from the package table; all-zero state is unreachable.
- in_valid without in_ready: ignored. The bench holds the pair, and no latching occurs.
- Reset mid-RUN: stream aborts immediately to reset values; done is not pulsed.

Optional Feature:
SC_SNG_HOLD_EN
- Defined:
  - hold port exists.
  - hold=1 in RUN freezes the LFSRs and counter, forces stream_valid = 0, and forces dividend, divisor and rand_num to 0.
  - in_ready = 0 while hold=1.
  - done is deferred until the last bit is actually emitted.
  - hold in IDLE has no effect.
- Undefined: no hold port; behaviour as above.

Decomposition:
- Package sc_sng_pkg:
  - state enum (IDLE, RUN);
  - function lfsr_taps(width) returning the maximal-length tap mask for widths 4..16;
  - localparam helper for period length 2^WIDTH-1.
- Sub-module sc_lfsr (WIDTH, SEED): ports clk, rst_n, en, reseed, state. Instantiated twice: operand LFSR and rand LFSR.
- FSM, counter, comparators and handshake live in the top module.

Test Plan:
- WIDTH=8, accept 64/128 → 255 stream_valid cycles; dividend ones=64, divisor ones=128; zero cycles with dividend=1 and divisor=0; done on cycle 255; err=0.
- Accept 0/0 → 255 valid cycles, all bits 0, done pulses; then accept 255/255 → all 255 bits 1 on both streams.
- Accept 200/100 → err=1 for one cycle after accept; dividend ones=100, divisor ones=100.
- in_valid held high with pairs 10/20 then 30/40, second accepted on the done cycle → stream_valid high 510 consecutive cycles; ones counts 10,20 then 30,40; two done pulses.
- rst_n low at RUN cycle 100 → all outputs 0 asynchronously, in_ready=1, no done; a fresh accept then produces an exact count.
- SC_SNG_HOLD_EN defined: accept 64/128 with hold=1 for 50 cycles mid-run → 305 cycles to done; valid-bit ones counts still 64/128; stream_valid=0 during hold.

Source files
------------

// File: rtl/sc_sng_pkg.sv
// Shared types and LFSR helpers for the stochastic operand generator.
package sc_sng_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} sng_state_t;

  localparam int unsigned LFSR_MAX_W = 16;

  // Maximal-length tap masks (bit n-1 set for tap n), widths 4..16
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  // One Fibonacci step: shift left, feedback into bit 0, masked to width
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] s,
                                                      input int unsigned width);
    logic                  fb;
    logic [LFSR_MAX_W-1:0] mask;
    mask = LFSR_MAX_W'((32'd1 << width) - 32'd1);
    fb   = ^(s & lfsr_taps(width));
    return ((s << 1) | {15'd0, fb}) & mask;
  endfunction

  function automatic int unsigned sng_period(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous reseed and step enable.
module sc_lfsr
  import sc_sng_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             reseed,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WIDTH'(SEED);
    end else if (reseed) begin
      state <= WIDTH'(SEED);
    end else if (en) begin
      state <= WIDTH'(lfsr_step(LFSR_MAX_W'(state), WIDTH));
    end
  end

endmodule

// File: rtl/sc_div_operand_gen.sv
// Binary-to-stochastic encoder feeding the correlation-based divider.
// Optional stall input enabled by defining SC_SNG_HOLD_EN.
module sc_div_operand_gen
  import sc_sng_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SEED   = 1,
  parameter int unsigned SEED_R = (1 << (WIDTH - 1)) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend_val,
  input  logic [WIDTH-1:0] divisor_val,
  output logic             dividend,
  output logic             divisor,
  output logic             rand_num,
  output logic             stream_valid,
  output logic             done,
  output logic             err
`ifdef SC_SNG_HOLD_EN
  ,
  input  logic             hold
`endif
);

  localparam int unsigned      PERIOD   = sng_period(WIDTH);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_R_W = WIDTH'(SEED_R);

  sng_state_t       st_q, st_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] lfsr, lfsr_r, lfsr_d, lfsr_r_d;
  logic             accept, lfsr_en, hold_q, hold_nxt, emit_d;
  logic             in_ready_d, stream_valid_d, dividend_d, divisor_d, rand_d, done_d, err_d;
  logic             unused_rand_bits;

`ifdef SC_SNG_HOLD_EN
  assign hold_nxt = hold;
`else
  assign hold_nxt = 1'b0;
`endif

  assign unused_rand_bits = ^lfsr_r_d[WIDTH-2:0];

  sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr_op (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lfsr_en),
    .reseed (accept),
    .state  (lfsr)
  );

  sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_R)) u_lfsr_rand (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lfsr_en),
    .reseed (accept),
    .state  (lfsr_r)
  );

  // State register: FSM, period counter, latched operands, sampled stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hold_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hold_q <= hold_nxt;
    end
  end

  // Next state; outputs are decoded from next-state values so they register cleanly
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    lfsr_en  = 1'b0;
    accept   = in_valid && in_ready;
    lfsr_d   = lfsr;
    lfsr_r_d = lfsr_r;

    if (st_q == RUN && !hold_q) begin
      if (cnt_q == CNT_LAST) begin
        st_d = IDLE;
      end else begin
        cnt_d   = cnt_q + WIDTH'(1);
        lfsr_en = 1'b1;
      end
    end

    // Dividend is clamped so a_q <= b_q keeps the two streams nested
    if (accept) begin
      st_d  = RUN;
      cnt_d = '0;
      a_d   = (dividend_val > divisor_val) ? divisor_val : dividend_val;
      b_d   = divisor_val;
    end

    if (accept) begin
      lfsr_d   = SEED_W;
      lfsr_r_d = SEED_R_W;
    end else if (lfsr_en) begin
      lfsr_d   = WIDTH'(lfsr_step(LFSR_MAX_W'(lfsr), WIDTH));
      lfsr_r_d = WIDTH'(lfsr_step(LFSR_MAX_W'(lfsr_r), WIDTH));
    end

    emit_d         = (st_d == RUN) && !hold_nxt;
    in_ready_d     = (st_d == IDLE) || (emit_d && (cnt_d == CNT_LAST));
    stream_valid_d = emit_d;
    dividend_d     = emit_d && (lfsr_d <= a_d) && (a_d != '0);
    divisor_d      = emit_d && (lfsr_d <= b_d) && (b_d != '0);
    rand_d         = emit_d && lfsr_r_d[WIDTH-1];
    done_d         = emit_d && (cnt_d == CNT_LAST);
    err_d          = accept && (dividend_val > divisor_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      stream_valid <= 1'b0;
      dividend     <= 1'b0;
      divisor      <= 1'b0;
      rand_num     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      in_ready     <= in_ready_d;
      stream_valid <= stream_valid_d;
      dividend     <= dividend_d;
      divisor      <= divisor_d;
      rand_num     <= rand_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_sc_div_operand_gen.sv
// Directed self-checking bench for sc_div_operand_gen (WIDTH=8).
module tb_sc_div_operand_gen;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend_val;
  logic [W-1:0] divisor_val;
  logic         dividend;
  logic         divisor;
  logic         rand_num;
  logic         stream_valid;
  logic         done;
  logic         err;
`ifdef SC_SNG_HOLD_EN
  logic         hold;
`endif

  int total = 0;
  int bad   = 0;

  int n_valid, n_div, n_dvs, n_viol, n_rand, n_done, n_err, err_at, done_at, n_stray, n_ready;

  sc_div_operand_gen #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend_val (dividend_val),
    .divisor_val  (divisor_val),
    .dividend     (dividend),
    .divisor      (divisor),
    .rand_num     (rand_num),
    .stream_valid (stream_valid),
    .done         (done),
    .err          (err)
`ifdef SC_SNG_HOLD_EN
    ,
    .hold         (hold)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input int a, input int b);
    @(negedge clk);
    dividend_val = W'(a);
    divisor_val  = W'(b);
    in_valid     = 1'b1;
  endtask

  // Sample one stream from the cycle after accept until done (or budget runs out)
  task automatic collect(input int budget, input bit junk);
    n_valid = 0; n_div = 0; n_dvs = 0; n_viol = 0; n_rand = 0; n_done = 0;
    n_err = 0; err_at = 0; done_at = 0; n_stray = 0; n_ready = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (junk && c == 10) begin
        dividend_val = 8'd5;
        divisor_val  = 8'd9;
        in_valid     = 1'b1;
      end
      if (junk && c == 14) in_valid = 1'b0;
      if (stream_valid) begin
        n_valid++;
        if (dividend) n_div++;
        if (divisor) n_dvs++;
        if (rand_num) n_rand++;
        if (dividend && !divisor) n_viol++;
        if (in_ready) n_ready++;
      end else if (dividend || divisor || rand_num) begin
        n_stray++;
      end
      if (err) begin
        n_err++;
        if (err_at == 0) err_at = c;
      end
      if (done) begin
        n_done++;
        done_at = c;
        break;
      end
    end
  endtask

  initial begin
    int nv, dones, first_done, second_done;
    int div_s[2];
    int dvs_s[2];

    rst_n        = 1'b1;
    in_valid     = 1'b0;
    dividend_val = '0;
    divisor_val  = '0;
`ifdef SC_SNG_HOLD_EN
    hold         = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_stream_valid", int'(stream_valid), 0);
    chk("rst_bits", int'({dividend, divisor, rand_num}), 0);
    chk("rst_done_err", int'({done, err}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 64/128 with an ignored offer mid-run
    offer(64, 128);
    collect(300, 1'b1);
    chk("t1_valid", n_valid, 255);
    chk("t1_div_ones", n_div, 64);
    chk("t1_dvs_ones", n_dvs, 128);
    chk("t1_nesting", n_viol, 0);
    chk("t1_rand_ones", n_rand, 128);
    chk("t1_done_at", done_at, 255);
    chk("t1_err", n_err, 0);
    chk("t1_ready_in_run", n_ready, 1);
    chk("t1_stray", n_stray, 0);
    @(negedge clk);
    chk("t1_idle_valid", int'(stream_valid), 0);
    chk("t1_idle_ready", int'(in_ready), 1);

    // Zero operands, then full-scale operands
    offer(0, 0);
    collect(300, 1'b0);
    chk("t2_valid", n_valid, 255);
    chk("t2_div_ones", n_div, 0);
    chk("t2_dvs_ones", n_dvs, 0);
    chk("t2_done", n_done, 1);
    offer(255, 255);
    collect(300, 1'b0);
    chk("t2f_div_ones", n_div, 255);
    chk("t2f_dvs_ones", n_dvs, 255);
    chk("t2f_done_at", done_at, 255);

    // Dividend above divisor: error pulse and clamp
    offer(200, 100);
    collect(300, 1'b0);
    chk("t3_err_cnt", n_err, 1);
    chk("t3_err_at", err_at, 1);
    chk("t3_div_ones", n_div, 100);
    chk("t3_dvs_ones", n_dvs, 100);

    // Back-to-back pairs with in_valid held high
    nv = 0; dones = 0; first_done = 0; second_done = 0;
    div_s[0] = 0; div_s[1] = 0; dvs_s[0] = 0; dvs_s[1] = 0;
    offer(10, 20);
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) begin
        dividend_val = 8'd30;
        divisor_val  = 8'd40;
      end
      if (dones == 1 && c == first_done + 1) in_valid = 1'b0;
      if (stream_valid) begin
        nv++;
        if (dividend) div_s[dones]++;
        if (divisor) dvs_s[dones]++;
      end
      if (done) begin
        dones++;
        if (dones == 1) first_done = c;
        else begin
          second_done = c;
          break;
        end
      end
    end
    in_valid = 1'b0;
    chk("t4_first_done", first_done, 255);
    chk("t4_second_done", second_done, 510);
    chk("t4_valid_run", nv, 510);
    chk("t4_div0", div_s[0], 10);
    chk("t4_dvs0", dvs_s[0], 20);
    chk("t4_div1", div_s[1], 30);
    chk("t4_dvs1", dvs_s[1], 40);
    @(negedge clk);
    chk("t4_idle_valid", int'(stream_valid), 0);

    // Asynchronous reset in the middle of a stream
    offer(50, 60);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
    end
    chk("t5_running", int'(stream_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(stream_valid), 0);
    chk("t5_rst_ready", int'(in_ready), 1);
    chk("t5_rst_bits", int'({dividend, divisor, rand_num}), 0);
    chk("t5_rst_done", int'(done), 0);
    @(negedge clk);
    chk("t5_rst_done_hold", int'(done), 0);
    rst_n = 1'b1;
    offer(77, 99);
    collect(300, 1'b0);
    chk("t5_div_ones", n_div, 77);
    chk("t5_dvs_ones", n_dvs, 99);
    chk("t5_done_at", done_at, 255);

`ifdef SC_SNG_HOLD_EN
    // Stall for 50 cycles mid-run
    n_valid = 0; n_div = 0; n_dvs = 0; n_stray = 0; n_ready = 0; done_at = 0;
    nv = 0;
    offer(64, 128);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (stream_valid) begin
        n_valid++;
        if (dividend) n_div++;
        if (divisor) n_dvs++;
      end else begin
        nv++;
        if (dividend || divisor || rand_num) n_stray++;
        if (in_ready) n_ready++;
      end
      if (done) begin
        done_at = c;
        break;
      end
      if (c == 100) hold = 1'b1;
      if (c == 150) hold = 1'b0;
    end
    chk("t6_done_at", done_at, 305);
    chk("t6_valid", n_valid, 255);
    chk("t6_stalled", nv, 50);
    chk("t6_div_ones", n_div, 64);
    chk("t6_dvs_ones", n_dvs, 128);
    chk("t6_stray", n_stray, 0);
    chk("t6_ready_held", n_ready, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
